// File: rtl/rgb_win_pkg.sv
// Shared types and constants for the 3x3 RGB window streamer.
package rgb_win_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INGEST,
    EMIT,
    FLUSH
  } state_e;

  localparam int                    DATA_W_DEF = 24;
  localparam int                    TAPS       = 9;
  localparam logic [DATA_W_DEF-1:0] PAD_PIX    = '0;
  // Slot index that never holds a row; used to request a zero-padded tap.
  localparam logic [1:0]            NO_SLOT    = 2'd3;

  // Row offset index of a tap: 0 -> dy=-1, 1 -> dy=0, 2 -> dy=+1.
  function automatic logic [1:0] tap_dy(input logic [3:0] tap);
    if (tap < 4'd3)      return 2'd0;
    else if (tap < 4'd6) return 2'd1;
    else                 return 2'd2;
  endfunction

  // Column offset index of a tap: 0 -> dx=-1, 1 -> dx=0, 2 -> dx=+1.
  function automatic logic [1:0] tap_dx(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

endpackage

// File: rtl/rgb_line_buffer.sv
// Three-row pixel ring: one synchronous write port, one combinational read that
// returns zero for an invalid slot or a column outside the row.
module rgb_line_buffer
  import rgb_win_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CW     = $clog2(IMG_W)
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [1:0]        wr_slot,
  input  logic [CW-1:0]     wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        rd_slot,
  input  logic [CW:0]       rd_col,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [3][IMG_W];

  // NOTE: the array has no reset; every row is rewritten before any window reads it.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_slot][wr_col] <= wr_data;
  end

  always_comb begin
    rd_data = DATA_W'(PAD_PIX);
    if (rd_slot != NO_SLOT && rd_col < (CW+1)'(IMG_W)) begin
      rd_data = mem_q[rd_slot][rd_col[CW-1:0]];
    end
  end

endmodule

// File: rtl/rgb_window_streamer.sv
// 3x3 zero-padded window streamer: buffers rows in a 3-slot ring and replays nine
// beats per pixel. Defining RGB_WIN_EOF_EN adds the o_frame_done end-of-frame pulse.
module rgb_window_streamer
  import rgb_win_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_vld,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              i_pix_busy,
  output logic              o_rgb_vld,
  output logic [DATA_W-1:0] o_rgb_data,
  input  logic              o_rgb_busy
`ifdef RGB_WIN_EOF_EN
  ,
  output logic              o_frame_done
`endif
);

  localparam int                CW       = $clog2(IMG_W);
  localparam int                RW       = $clog2(IMG_H + 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_TOP  = RW'(2);
  localparam logic [RW-1:0]     ROW_END  = RW'(IMG_H);
  localparam logic [3:0]        TAP_LAST = 4'(TAPS - 1);
  localparam logic [DATA_W-1:0] PAD      = DATA_W'(PAD_PIX);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [3:0]        tap_q, tap_d;
  logic [1:0]        wslot_q, wslot_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              pix_acc, beat_acc, row_last_pix, row_last_beat;
  logic [1:0]        dy, dx, ctr_slot, rd_slot;
  logic [CW:0]       rd_col;
  logic [DATA_W-1:0] rd_data;

  assign i_pix_busy    = (state_q != INGEST);
  assign o_rgb_vld     = vld_q;
  assign o_rgb_data    = data_q;
  assign pix_acc       = i_pix_vld && (state_q == INGEST);
  assign beat_acc      = vld_q && !o_rgb_busy && (state_q == EMIT || state_q == FLUSH);
  assign row_last_pix  = pix_acc && (col_q == COL_LAST);
  assign row_last_beat = beat_acc && (tap_q == TAP_LAST) && (col_q == COL_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    col_d = col_q;
    tap_d = tap_q;
    if (pix_acc) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    end else if (beat_acc) begin
      if (tap_q != TAP_LAST) begin
        tap_d = tap_q + 4'd1;
      end else begin
        tap_d = '0;
        col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
      end
    end
  end

  // Address of the beat loaded next; wslot_q is the slot of row row_q.
  always_comb begin
    dy       = tap_dy(tap_d);
    dx       = tap_dx(tap_d);
    ctr_slot = (state_q == FLUSH) ? add_mod3(wslot_q, 2'd2) : add_mod3(wslot_q, 2'd1);
    rd_slot  = add_mod3(ctr_slot, add_mod3(dy, 2'd2));
    if ((dy == 2'd0 && state_q == EMIT && row_q == ROW_TOP) ||
        (dy == 2'd2 && state_q == FLUSH)) begin
      rd_slot = NO_SLOT;
    end
    rd_col = {1'b0, col_d} + (CW+1)'(dx) - (CW+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wslot_d = wslot_q;
    vld_d   = vld_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: state_d = INGEST;
      INGEST: begin
        if (row_last_pix) begin
          row_d   = row_q + RW'(1);
          wslot_d = add_mod3(wslot_q, 2'd1);
          // First beat of any center row is the dx=-1 tap of column 0: always padding.
          if (row_q != '0) begin
            state_d = EMIT;
            vld_d   = 1'b1;
            data_d  = PAD;
          end
        end
      end
      EMIT, FLUSH: begin
        if (row_last_beat) begin
          data_d = PAD;
          if (state_q == EMIT && row_q == ROW_END) begin
            state_d = FLUSH;
          end else begin
            state_d = INGEST;
            vld_d   = 1'b0;
            if (state_q == FLUSH) begin
              row_d   = '0;
              wslot_d = '0;
            end
          end
        end else if (beat_acc) begin
          data_d = rd_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      tap_q   <= '0;
      wslot_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tap_q   <= tap_d;
      wslot_q <= wslot_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

`ifdef RGB_WIN_EOF_EN
  logic done_q, done_d;
  assign done_d       = row_last_beat && (state_q == FLUSH);
  assign o_frame_done = done_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) done_q <= 1'b0;
    else        done_q <= done_d;
  end
`endif

  rgb_line_buffer #(
    .IMG_W (IMG_W),
    .DATA_W(DATA_W),
    .CW    (CW)
  ) u_line_buffer (
    .i_clk  (i_clk),
    .wr_en  (pix_acc),
    .wr_slot(wslot_q),
    .wr_col (col_q),
    .wr_data(i_pix_data),
    .rd_slot(rd_slot),
    .rd_col (rd_col),
    .rd_data(rd_data)
  );

endmodule

// File: doc/rgb_window_streamer.md
# rgb_window_streamer

Upstream feeder for DC_Filter. Accepts a row-major 24-bit RGB frame and buffers it in a 3-row ring. For every pixel it replays the 3x3 neighbourhood as nine consecutive 24-bit beats, zero-padded at the borders, on the busy/vld channel that DC_Filter's `i_rgb` port consumes. The block sits between the frame source and DC_Filter and sustains one window beat per cycle while the downstream side is not busy.

## Interface
- `IMG_W`, default 256: frame width in pixels (≥2).
- `IMG_H`, default 256: frame height in rows (≥2).
- `DATA_W`, default 24: pixel width; R in [23:16], G in [15:8], B in [7:0].
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst`, in, 1: reset; asynchronous assert, active-low.
- `i_pix_vld`, in, 1: source pixel valid.
- `i_pix_data`, in, DATA_W: source pixel.
- `i_pix_busy`, out, 1: block cannot accept a pixel.
- `o_rgb_vld`, out, 1: window beat valid; drives DC_Filter `i_rgb_vld`.
- `o_rgb_data`, out, DATA_W: window beat; drives DC_Filter `i_rgb_data`.
- `o_rgb_busy`, in, 1: downstream busy; driven by DC_Filter `i_rgb_busy`.

## Operation
- Transfer rule on both channels: a beat moves on a rising edge with vld=1 and busy=0. A producer holds vld and data stable while busy=1.
- Storage: 3 row slots of IMG_W pixels each. Source row r is written to slot r mod 3.
- FSM states:
  - IDLE: goes straight to INGEST on the first cycle after reset.
  - INGEST: accepts one full row (IMG_W pixels). i_pix_busy=0.
  - EMIT: outputs the windows for one center row. i_pix_busy=1.
  - FLUSH: outputs the windows for the last center row, with no input.
- Sequence:
  - INGEST row 0, then INGEST row 1, then EMIT center row 0.
  - After that, for each r = 2..IMG_H-1: INGEST row r, then EMIT center row r-1.
  - Then FLUSH center row IMG_H-1, then return to INGEST for row 0 of the next frame.
- Window order per center (x,y): dy = -1, 0, +1 (outer), dx = -1, 0, +1 (inner), 9 beats. Centers are visited x = 0..IMG_W-1 within a row.
- Out-of-range taps output 24'h000000. Out-of-range means x+dx outside 0..IMG_W-1, y+dy < 0, or y+dy = IMG_H.
- Counters: column `$clog2(IMG_W)` bits, row `$clog2(IMG_H+1)` bits, tap 4 bits (0..8). All wrap to 0 at their terminal count.
- Source pixels presented while i_pix_busy=1 are ignored; the source must hold them.
- A reset asserted mid-frame discards all buffered rows and the partial window. The next frame starts from row 0.

## Timing
- Reset values:
  - i_pix_busy=1 while i_rst=0; drops to 0 on the first edge after release.
  - o_rgb_vld=0, o_rgb_data=0, state=IDLE, all counters 0.
- Output is registered. The first beat of EMIT/FLUSH is valid 1 cycle after the last INGEST pixel is accepted.
- Sustained rate: 1 beat per cycle while o_rgb_busy=0. With o_rgb_busy=1, o_rgb_vld and o_rgb_data hold; no beat is lost or duplicated.
- INGEST to EMIT: the edge that accepts pixel IMG_W-1 also sets i_pix_busy=1.
- EMIT to INGEST: the edge that accepts beat 9 of center IMG_W-1 clears i_pix_busy and drops o_rgb_vld (unless the next state is FLUSH).
- Per frame: IMG_W*IMG_H input cycles and 9*IMG_W*IMG_H output beats, at minimum.

## Configuration
- `RGB_WIN_EOF_EN` defined:
  - Adds output port `o_frame_done` (1 bit, reset 0).
  - It pulses high for exactly one cycle, on the cycle after the final FLUSH beat is accepted.
- Not defined: the port is absent. Behaviour is otherwise identical.

## Structure
- Package `rgb_win_pkg` holds:
  - the FSM state enum (IDLE, INGEST, EMIT, FLUSH);
  - the `DATA_W` default;
  - the tap-count constant 9;
  - the zero-pad constant.
- Sub-module `rgb_line_buffer`: 3 x IMG_W register array with one write port and a combinational read of (slot, col). It returns 0 when the read is out of range.
- Top level holds the FSM, counters, padding decode and output register.

## Test plan
- Reset:
  - Hold i_rst=0 for 3 cycles → i_pix_busy=1, o_rgb_vld=0, o_rgb_data=0.
  - One cycle after release → i_pix_busy=0.
- First window (IMG_W=4, IMG_H=3; pixel n = n+1 replicated in R/G/B, i.e. 1..12):
  - Stream the frame → first 9 beats are 0,0,0,0,1,2,0,5,6 (per-channel value).
- Last window (same frame):
  - Final 9 beats are 7,8,0,11,12,0,0,0,0.
  - Total 108 beats, then i_pix_busy=0 for the next frame.
- Backpressure:
  - Raise o_rgb_busy for 5 cycles at beat 4 → o_rgb_data held constant.
  - Beat sequence is identical to the unstalled run.
- Ignored input:
  - Assert i_pix_vld with data 0xFFFFFF during EMIT → no write occurs; window contents unchanged.
- Mid-frame reset (with `RGB_WIN_EOF_EN`):
  - Reset after 6 pixels, then send a full frame → first window is 0,0,0,0,1,2,0,5,6.
  - o_frame_done pulses once, one cycle after beat 108.
